// File: rtl/exe_mem_skid_stage_if.sv
// EXE -> MEM stage bus: upstream valid/ready plus payload, downstream
// valid/ready plus the head entry. The stage takes the slave view, the
// surrounding logic (EXE/MEM or a bench) takes the master view.
interface exe_mem_skid_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic [ADDR_W-1:0] alu_result_in;
  logic [DATA_W-1:0] st_val_in;
  logic [DEST_W-1:0] dest_in;

  logic              out_valid;
  logic              out_ready;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic [DEST_W-1:0] dest;

  modport slave (
    input  in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
    input  alu_result_in, st_val_in, dest_in,
    output in_ready,
    output out_valid, wb_en, mem_r_en, mem_w_en, address, data, dest,
    input  out_ready
  );

  modport master (
    output in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
    output alu_result_in, st_val_in, dest_in,
    input  in_ready,
    input  out_valid, wb_en, mem_r_en, mem_w_en, address, data, dest,
    output out_ready
  );
endinterface

// File: rtl/exe_mem_skid_stage.sv
// EXE -> MEM pipeline stage. Holds up to two entries (SKID=1, registered
// in_ready) or one entry (SKID=0, combinational in_ready), with synchronous
// flush and a saturating count of stalled cycles. freeze from the cache
// controller simply masks out_ready, so the head entry holds while frozen.
module exe_mem_skid_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  exe_mem_skid_stage_if.slave  bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } ent_t;

  state_t           st_q, st_d;
  ent_t             main_q, main_d, skid_q, skid_d, in_ent;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy_eff, out_valid, in_ready, accept, pop;

  assign rdy_eff   = bus.out_ready & ~freeze;
  assign out_valid = (st_q != EMPTY);
  assign accept    = bus.in_valid & in_ready;
  assign pop       = out_valid & rdy_eff;

  assign in_ent = '{wb_en:    bus.wb_en_in,
                    mem_r_en: bus.mem_r_en_in,
                    mem_w_en: bus.mem_w_en_in,
                    addr:     bus.alu_result_in,
                    data:     bus.st_val_in,
                    dest:     bus.dest_in};

  if (SKID != 0) begin : g_skid
    logic rdy_q;
    // in_ready is a flop: next cycle can accept unless we are heading to FULL
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_q <= 1'b1;
      else     rdy_q <= (st_d != FULL);
    end
    assign in_ready = rdy_q;
  end else begin : g_noskid
    // single entry: accept when empty or when the head leaves this cycle;
    // forced low while reset is held so the whole port reads idle
    assign in_ready = (~out_valid | rdy_eff) & ~rst;
  end

  // Next state and entry movement. With SKID=0 the ONE->FULL arc is
  // unreachable because accept in ONE implies pop.
  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      st_d = EMPTY;
    end else begin
      case (st_q)
        EMPTY: begin
          if (accept) begin
            st_d   = ONE;
            main_d = in_ent;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_ent;
          end else if (accept) begin
            st_d   = FULL;
            skid_d = in_ent;
          end else if (pop) begin
            st_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            st_d   = ONE;
            main_d = skid_q;
          end
        end
        default: st_d = EMPTY;
      endcase
    end
  end

  // State and payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      st_q   <= st_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Saturating count of cycles where a valid head is held back
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             cnt_q <= '0;
    else if (out_valid && !rdy_eff && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.wb_en     = main_q.wb_en    & out_valid;
  assign bus.mem_r_en  = main_q.mem_r_en & out_valid;
  assign bus.mem_w_en  = main_q.mem_w_en & out_valid;
  assign bus.address   = main_q.addr;
  assign bus.data      = main_q.data;
  assign bus.dest      = main_q.dest;

  assign occupancy = (st_q == FULL) ? 2'd2 : (st_q == ONE) ? 2'd1 : 2'd0;
  assign stall_cnt = cnt_q;

endmodule
